// File: rtl/led_request_sequencer.sv
// Fixed-priority time-sharing of one status LED: grants a requester, plays its
// n-flash blink code on a prescaled tick, appends a dark gap, then pulses done.
`timescale 1ns/1ps
module led_request_sequencer #(
  parameter int CLK_HZ    = 25000000,
  parameter int TICK_HZ   = 10,
  parameter int N_REQ     = 4,
  parameter int CNT_W     = 4,
  parameter int GAP_TICKS = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] count,
  output logic [N_REQ-1:0]       grant,
  output logic                   busy,
  output logic                   done,
  output logic                   led_out
);
  localparam int DIV    = CLK_HZ / TICK_HZ;
  localparam int PCNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GAP_W  = $clog2(GAP_TICKS + 1);
  localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(DIV - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_TICKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_e;

  state_e             state_q, state_d;
  logic [PCNT_W-1:0]  pcnt_q, pcnt_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               led_q, led_d;

  logic               tick;
  logic               win_valid;
  logic [N_REQ-1:0]   win_oh;
  logic [CNT_W-1:0]   win_cnt;

  assign tick = (pcnt_q == PCNT_MAX);

  // Lowest-index requester with a non-zero count wins.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first, so no path leaves it unassigned and no latch is inferred.
    win_valid = 1'b0;
    win_oh    = '0;
    win_cnt   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!win_valid && req[k] && (count[k*CNT_W +: CNT_W] != '0)) begin
        win_valid = 1'b1;
        win_oh[k] = 1'b1;
        win_cnt   = count[k*CNT_W +: CNT_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    gap_d       = gap_q;
    pcnt_d      = tick ? '0 : pcnt_q + PCNT_W'(1);
    case (state_q)
      S_IDLE: begin
        if (win_valid) begin
          state_d     = S_ON;
          remaining_d = win_cnt;
          pcnt_d      = '0;   // phase boundaries align to the grant cycle
        end
      end
      S_ON: if (tick) state_d = S_OFF;
      S_OFF: begin
        if (tick) begin
          if (remaining_q == CNT_W'(1)) begin
            state_d = S_GAP;
            gap_d   = '0;
          end else begin
            state_d     = S_ON;
            remaining_d = remaining_q - CNT_W'(1);
          end
        end
      end
      S_GAP: begin
        if (tick) begin
          if (gap_q == GAP_LAST) state_d = S_IDLE;
          else                   gap_d   = gap_q + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are the registered image of the next state, so nothing is combinational to the pins.
  always_comb begin
    led_d   = (state_d == S_ON);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_q == S_GAP) && (state_d == S_IDLE);
    grant_d = grant_q;
    if (state_d == S_IDLE)      grant_d = '0;
    else if (state_q == S_IDLE) grant_d = win_oh;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pcnt_q      <= '0;
      remaining_q <= '0;
      gap_q       <= '0;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      led_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge value of the others.
      state_q     <= state_d;
      pcnt_q      <= pcnt_d;
      remaining_q <= remaining_d;
      gap_q       <= gap_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      led_q       <= led_d;
    end
  end

  assign grant   = grant_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign led_out = led_q;
endmodule

// File: tb/tb_led_request_sequencer.sv
// Bench for led_request_sequencer: service-timeline reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_led_request_sequencer;
  localparam int CLK_HZ = 100;
  localparam int TICK_HZ = 10;
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int N = 4;
  localparam int CW = 4;
  localparam int GAP = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N*CW-1:0] count = '0;
  logic [N-1:0]  grant;
  logic          busy, done, led_out;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  led_request_sequencer #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .N_REQ(N), .CNT_W(CW), .GAP_TICKS(GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .count(count),
    .grant(grant), .busy(busy), .done(done), .led_out(led_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a service is a timeline of (2n+GAP)*DIV cycles starting at the grant cycle.
  bit m_active, m_done;
  int m_k, m_n, m_r;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0;
      m_done   = 0;
    end else if (m_active) begin
      m_r++;
      m_done = (m_r == (2 * m_n + GAP) * DIV);
      if (m_done) m_active = 0;
    end else begin
      m_done = 0;
      for (int k = 0; k < N; k++) begin
        if (!m_active && req[k] && count[k*CW +: CW] != 0) begin
          m_active = 1;
          m_k = k;
          m_n = int'(count[k*CW +: CW]);
          m_r = 0;
        end
      end
    end
  end

  always @(posedge clk) begin
    logic [N-1:0] e_grant;
    logic         e_led;
    #1;
    e_grant = m_active ? (N'(1) << m_k) : '0;
    e_led   = m_active && (m_r < 2 * m_n * DIV) && ((m_r / DIV) % 2 == 0);
    check("model_grant", grant, e_grant);
    check("model_busy", busy, m_active);
    check("model_done", done, m_done);
    check("model_led", led_out, e_led);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check("reset_grant", grant, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_led", led_out, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step(2);

    // Single code, count 3
    req = 4'b0001; count = 16'h0003;
    step(1);  check("single_grant_t1", grant, 4'b0001); check("single_led_t1", led_out, 1);
    check("single_busy_t1", busy, 1);
    step(9);  check("single_led_t10", led_out, 1);
    step(1);  check("single_led_t11", led_out, 0);
    step(70); check("single_done_t81", done, 1); check("single_grant_t81", grant, 0);
    req = '0;
    step(1);  check("single_after", grant, 0);

    // Simultaneous requests 1 and 2
    req = 4'b0110; count = 16'h0120;
    step(1);  check("simul_grant1", grant, 4'b0010);
    step(60); check("simul_done1", done, 1);
    req = 4'b0100;
    step(1);  check("simul_grant2", grant, 4'b0100);
    step(40); check("simul_done2", done, 1);
    req = '0;
    step(1);

    // Zero count ignored
    req = 4'b1001; count = 16'h1000;
    step(1);  check("zero_grant3", grant, 4'b1000);
    step(40); check("zero_done", done, 1);
    req = 4'b0001;
    step(5);  check("zero_only_grant", grant, 0); check("zero_only_busy", busy, 0);
    step(30); check("zero_only_late", grant, 0);
    req = '0;
    step(1);

    // Request dropped mid-service
    req = 4'b0001; count = 16'h0002;
    step(5);  req = '0;
    step(15); check("drop_led_t20", led_out, 0);
    step(1);  check("drop_led_t21", led_out, 1);
    step(40); check("drop_done", done, 1);
    step(1);  check("drop_noregrant", grant, 0);
    step(20); check("drop_noregrant_late", grant, 0);

    // No preemption
    req = 4'b0100; count = 16'h0201;
    step(12); req = 4'b0101;
    check("nopre_grant_off", grant, 4'b0100);
    step(49); check("nopre_done", done, 1); check("nopre_done_grant", grant, 0);
    req = 4'b0001;
    step(1);  check("nopre_next", grant, 4'b0001);
    step(40); check("nopre_done2", done, 1);
    req = '0;
    step(1);

    // Reset mid-service
    req = 4'b0001; count = 16'h0004;
    step(3);  check("rst_pre_led", led_out, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_led", led_out, 0);
    check("rst_async_grant", grant, 0);
    check("rst_async_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step(1);  check("rst_regrant", grant, 4'b0001); check("rst_regrant_led", led_out, 1);
    step(9);  check("rst_led_t10", led_out, 1);
    step(1);  check("rst_led_t11", led_out, 0);
    step(90); check("rst_done", done, 1);
    req = '0;
    step(1);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) req = N'($urandom);
      if ($urandom_range(0, 15) == 0) count = (N*CW)'($urandom) & 16'h7777;
      if ($urandom_range(0, 63) == 0) count[$urandom_range(0, N-1)*CW +: CW] = 4'hF;
      if ($urandom_range(0, 1499) == 0) begin
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
      end
      step(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
